// File: rtl/pulse_train_pkg.sv
// Shared types and defaults for the pulse-train transmitter/receiver pair.
// Holds the state encoding and the nominal burst shape.
package pulse_train_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2,
        SKIP = 2'd3
    } pt_state_e;

    localparam int PT_HIGH_W    = 2;
    localparam int PT_LOW_W     = 1;
    localparam int PT_NUM_PULSE = 3;

    function automatic int pt_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pulse_train_det.sv
// Receive-side checker for a fixed-shape pulse burst on one line.
// Measures high/low run lengths and flags complete or malformed trains.
module pulse_train_det
    import pulse_train_pkg::*;
#(
    parameter int HIGH_W    = PT_HIGH_W,
    parameter int LOW_W     = PT_LOW_W,
    parameter int NUM_PULSE = PT_NUM_PULSE
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           din,
    output logic                           det,
    output logic                           err,
    output logic                           busy,
    output logic [$clog2(NUM_PULSE+1)-1:0] pcnt
);

    localparam int RW = $clog2(pt_max(HIGH_W, LOW_W) + 2);
    localparam int PW = $clog2(NUM_PULSE + 1);

    localparam logic [RW-1:0] HI  = RW'(HIGH_W);
    localparam logic [RW-1:0] LO  = RW'(LOW_W);
    localparam logic [RW-1:0] ONE = RW'(1);
    localparam logic [PW-1:0] NP  = PW'(NUM_PULSE);

    pt_state_e     state, state_n;
    logic [RW-1:0] run, run_n;
    logic [PW-1:0] pcnt_n, pcnt_inc;
    logic          det_n, err_n;

    // Saturating increment; run never needs to exceed its top value.
    function automatic logic [RW-1:0] sat_inc(input logic [RW-1:0] v);
        return (v == {RW{1'b1}}) ? v : v + ONE;
    endfunction

    assign pcnt_inc = pcnt + PW'(1);

    // Next-state, run/pulse counters and strobes from current state and din.
    always_comb begin
        state_n = state;
        run_n   = run;
        pcnt_n  = pcnt;
        det_n   = 1'b0;
        err_n   = 1'b0;
        if (!en) begin
            state_n = IDLE;
            run_n   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (din) begin
                        state_n = HIGH;
                        run_n   = ONE;
                        pcnt_n  = '0;
                    end
                end
                HIGH: begin
                    if (din) begin
                        if (run < HI) begin
                            run_n = sat_inc(run);
                        end else begin
                            err_n   = 1'b1;
                            state_n = SKIP;
                        end
                    end else if (run != HI) begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                        run_n   = '0;
                    end else if (pcnt_inc == NP) begin
                        det_n   = 1'b1;
                        pcnt_n  = NP;
                        state_n = IDLE;
                        run_n   = '0;
                    end else begin
                        pcnt_n  = pcnt_inc;
                        state_n = GAP;
                        run_n   = ONE;
                    end
                end
                GAP: begin
                    if (!din) begin
                        if (run < LO) begin
                            run_n = sat_inc(run);
                        end else begin
                            err_n   = 1'b1;
                            state_n = IDLE;
                            run_n   = '0;
                        end
                    end else begin
                        // A short gap is flagged but the line keeps tracking.
                        err_n   = (run != LO);
                        state_n = HIGH;
                        run_n   = ONE;
                    end
                end
                SKIP: begin
                    if (!din) begin
                        state_n = IDLE;
                        run_n   = '0;
                    end
                end
                default: begin
                    state_n = IDLE;
                    run_n   = '0;
                end
            endcase
        end
    end

    // State, counters and registered outputs; reset aborts silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            run   <= '0;
            pcnt  <= '0;
            det   <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            run   <= run_n;
            pcnt  <= pcnt_n;
            det   <= det_n;
            err   <= err_n;
            busy  <= (state_n != IDLE);
        end
    end

endmodule
